// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Anode and cathode patterns are active-low.
package display_pkg;

    localparam logic [3:0] AN_D0  = 4'b0111;
    localparam logic [3:0] AN_D1  = 4'b1011;
    localparam logic [3:0] AN_D2  = 4'b1101;
    localparam logic [3:0] AN_D3  = 4'b1110;
    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        SHOW_A,
        SHOW_B
    } arb_state_t;

    // Digit 0 is the leftmost anode.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = AN_D0;
            2'd1:    an = AN_D1;
            2'd2:    an = AN_D2;
            default: an = AN_D3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Pattern bit 6 is segment a, bit 0 is segment g.
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        case (nibble)
            4'h0:    pattern = 7'b0000001;
            4'h1:    pattern = 7'b1001111;
            4'h2:    pattern = 7'b0010010;
            4'h3:    pattern = 7'b0000110;
            4'h4:    pattern = 7'b1001100;
            4'h5:    pattern = 7'b0100100;
            4'h6:    pattern = 7'b0100000;
            4'h7:    pattern = 7'b0001111;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0000100;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b1100000;
            4'hC:    pattern = 7'b0110001;
            4'hD:    pattern = 7'b1000010;
            4'hE:    pattern = 7'b0110000;
            default: pattern = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with inter-digit blanking,
// leading-zero suppression and a frame-aligned counter/message arbiter.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DIV         = 50000,
    parameter int unsigned BLANK       = 1000,
    parameter int unsigned HOLD_FRAMES = 1000
) (
    input  logic        CLK_in,
    input  logic        RST_in,
    input  logic [15:0] Data,
    input  logic [15:0] Msg_data,
    input  logic        Msg_req,
    output logic        Msg_ack,
    input  logic        Lz_en,
    output logic [3:0]  segment,
    output logic [6:0]  position,
    output logic        frame_start
);

    localparam int          CNT_W     = $clog2(DIV);
    localparam int          HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int unsigned ON_CYCLES = DIV - BLANK;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0]  cnt;
    logic [1:0]        idx;
    logic [HOLD_W-1:0] hold;
    logic [15:0]       disp;
    logic              lz_q;
    arb_state_t        state;

    logic       slot_end;
    logic       frame_end;
    logic       on_phase;
    logic       suppress;
    logic       lit;
    logic [3:0] nib;
    logic [6:0] pattern;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    assign on_phase  = (32'(cnt) < ON_CYCLES);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement or block order.
    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Source, hold count and suppression mode only change at frame boundaries.
    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            state   <= SHOW_A;
            hold    <= '0;
            disp    <= '0;
            lz_q    <= 1'b0;
            Msg_ack <= 1'b0;
        end else begin
            // NOTE: a default assignment followed by a conditional override is
            // safe here; the last non-blocking assignment in the block wins.
            Msg_ack <= 1'b0;
            if (frame_end) begin
                lz_q <= Lz_en;
                case (state)
                    SHOW_A: begin
                        if (Msg_req) begin
                            disp    <= Msg_data;
                            hold    <= HOLD_W'(HOLD_FRAMES - 1);
                            Msg_ack <= 1'b1;
                            state   <= SHOW_B;
                        end else begin
                            disp <= Data;
                        end
                    end
                    SHOW_B: begin
                        if (hold == '0) begin
                            disp  <= Data;
                            state <= SHOW_A;
                        end else begin
                            hold <= hold - HOLD_W'(1);
                        end
                    end
                    default: state <= SHOW_A;
                endcase
            end
        end
    end

    // NOTE: every variable written in always_comb gets a value on all paths
    // (default first), otherwise synthesis infers a latch.
    always_comb begin
        nib      = disp[15:12];
        suppress = 1'b0;
        case (idx)
            2'd0: begin
                nib      = disp[15:12];
                suppress = (disp[15:12] == 4'h0);
            end
            2'd1: begin
                nib      = disp[11:8];
                suppress = (disp[15:8] == 8'h00);
            end
            2'd2: begin
                nib      = disp[7:4];
                suppress = (disp[15:4] == 12'h000);
            end
            default: begin
                nib      = disp[3:0];
                suppress = 1'b0;
            end
        endcase
    end

    assign lit = on_phase && !(lz_q && suppress);

    hex_to_seg7 u_dec (
        .nibble  (nib),
        .pattern (pattern)
    );

    // Registered pin drivers: one cycle behind cnt/idx.
    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            segment     <= AN_OFF;
            position    <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            segment     <= lit ? anode_for(idx) : AN_OFF;
            position    <= lit ? pattern : SEG_OFF;
            frame_start <= (cnt == '0) && (idx == 2'd0);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV=8, BLANK=2, HOLD_FRAMES=3.
// Frame-level vectors give the expected cathode pattern per digit (7F = dark).
module tb_display_scan_ctrl;

    localparam int unsigned DIV         = 8;
    localparam int unsigned BLANK       = 2;
    localparam int unsigned HOLD_FRAMES = 3;

    localparam logic [6:0] DARK = 7'b1111111;

    localparam logic [0:3][6:0] P0000 = {4{7'b0000001}};
    localparam logic [0:3][6:0] P1111 = {4{7'b1001111}};
    localparam logic [0:3][6:0] P2222 = {4{7'b0010010}};
    localparam logic [0:3][6:0] PBEEF = {7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000};

    typedef struct packed {
        logic [15:0]       data;
        logic              lz;
        logic [0:3][6:0]   pos;
    } vec_t;

    logic        CLK_in = 1'b0;
    logic        RST_in;
    logic [15:0] Data;
    logic [15:0] Msg_data;
    logic        Msg_req;
    logic        Msg_ack;
    logic        Lz_en;
    logic [3:0]  segment;
    logic [6:0]  position;
    logic        frame_start;

    int tests = 0;
    int fails = 0;

    vec_t vecs [8];

    display_scan_ctrl #(
        .DIV         (DIV),
        .BLANK       (BLANK),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .CLK_in      (CLK_in),
        .RST_in      (RST_in),
        .Data        (Data),
        .Msg_data    (Msg_data),
        .Msg_req     (Msg_req),
        .Msg_ack     (Msg_ack),
        .Lz_en       (Lz_en),
        .segment     (segment),
        .position    (position),
        .frame_start (frame_start)
    );

    always #5 CLK_in = ~CLK_in;

    task automatic tick();
        @(posedge CLK_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] anode(input int d);
        case (d)
            0:       return 4'b0111;
            1:       return 4'b1011;
            2:       return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    // Checks one 32-cycle frame starting at its frame_start cycle. At cycle
    // chg_at the inputs Data/Msg_req/Msg_data are updated after the compare.
    task automatic check_frame(input string tag, input logic [0:3][6:0] pos, input int ack_at,
                               input int chg_at, input logic [15:0] nd, input logic nr,
                               input logic [15:0] nm);
        for (int i = 0; i < 4 * int'(DIV); i++) begin
            int d = i / int'(DIV);
            int c = i % int'(DIV);
            logic on = (c < int'(DIV - BLANK)) && (pos[d] != DARK);
            string nm_s = $sformatf("%s[%0d]", tag, i);
            check({nm_s, ".segment"}, 32'(segment), on ? 32'(anode(d)) : 32'hF);
            check({nm_s, ".position"}, 32'(position), on ? 32'(pos[d]) : 32'(DARK));
            check({nm_s, ".frame_start"}, 32'(frame_start), (i == 0) ? 32'd1 : 32'd0);
            check({nm_s, ".msg_ack"}, 32'(Msg_ack), (i == ack_at) ? 32'd1 : 32'd0);
            if (i == chg_at) begin
                Data     = nd;
                Msg_req  = nr;
                Msg_data = nm;
            end
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{data: 16'h12A4, lz: 1'b0,
                    pos: {7'b1001111, 7'b0010010, 7'b0001000, 7'b1001100}};
        vecs[1] = '{data: 16'h0070, lz: 1'b1,
                    pos: {DARK, DARK, 7'b0001111, 7'b0000001}};
        vecs[2] = '{data: 16'h0000, lz: 1'b1,
                    pos: {DARK, DARK, DARK, 7'b0000001}};
        vecs[3] = '{data: 16'h0000, lz: 1'b0, pos: P0000};
        vecs[4] = '{data: 16'h8F0A, lz: 1'b1,
                    pos: {7'b0000000, 7'b0111000, 7'b0000001, 7'b0001000}};
        vecs[5] = '{data: 16'h0B0C, lz: 1'b1,
                    pos: {DARK, 7'b1100000, 7'b0000001, 7'b0110001}};
        vecs[6] = '{data: 16'h3569, lz: 1'b0,
                    pos: {7'b0000110, 7'b0100100, 7'b0100000, 7'b0000100}};
        vecs[7] = '{data: 16'hDE00, lz: 1'b0,
                    pos: {7'b1000010, 7'b0110000, 7'b0000001, 7'b0000001}};

        RST_in   = 1'b1;
        Data     = 16'h12A4;
        Msg_data = 16'h0000;
        Msg_req  = 1'b0;
        Lz_en    = 1'b0;
        tick();
        tick();
        RST_in = 1'b0;
        // First cycle after release still shows the reset outputs.
        check("rst.segment", 32'(segment), 32'hF);
        check("rst.position", 32'(position), 32'h7F);
        check("rst.msg_ack", 32'(Msg_ack), 32'd0);
        check("rst.frame_start", 32'(frame_start), 32'd0);
        tick();

        // Each vector is applied during the frame before the one it is checked in.
        for (int v = 0; v < 8; v++) begin
            Data  = vecs[v].data;
            Lz_en = vecs[v].lz;
            check_frame($sformatf("pre_v%0d", v), (v == 0) ? P0000 : vecs[v-1].pos,
                        -1, -1, 16'h0, 1'b0, 16'h0);
        end
        Data  = 16'h1111;
        Lz_en = 1'b0;
        check_frame("v7", vecs[7].pos, -1, -1, 16'h0, 1'b0, 16'h0);

        // Mid-frame request: frame unchanged, ack on the boundary's next cycle.
        check_frame("req", P1111, 31, 10, 16'h1111, 1'b1, 16'hBEEF);
        check_frame("hold1", PBEEF, -1, 5, 16'h2222, 1'b1, 16'h0000);
        check_frame("hold2", PBEEF, -1, -1, 16'h0, 1'b1, 16'h0);
        check_frame("hold3", PBEEF, -1, 0, 16'h2222, 1'b1, 16'hBEEF);
        // Returning boundary ignores the still-high request; next one serves it.
        check_frame("ret_a", P2222, 31, 31, 16'h2222, 1'b0, 16'hBEEF);
        check_frame("hold1b", PBEEF, -1, -1, 16'h0, 1'b0, 16'h0);

        // Reset in the middle of the second held frame.
        for (int i = 0; i < 12; i++) tick();
        Data   = 16'h1111;
        RST_in = 1'b1;
        tick();
        RST_in = 1'b0;
        check("midrst.segment", 32'(segment), 32'hF);
        check("midrst.position", 32'(position), 32'h7F);
        check("midrst.msg_ack", 32'(Msg_ack), 32'd0);
        check("midrst.frame_start", 32'(frame_start), 32'd0);
        tick();

        check_frame("post_rst", P0000, -1, -1, 16'h0, 1'b0, 16'h0);
        check_frame("d1111", P1111, -1, 9, 16'h2222, 1'b0, 16'hBEEF);
        check_frame("d2222", P2222, -1, -1, 16'h0, 1'b0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
